// File: rtl/dlx_pkg.sv
// Shared types and defaults for the DLX multicycle phase sequencer.
package dlx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      IF_S,
      ID_S,
      EX_S,
      MEM_S,
      WB_S,
      HALTED,
      FAULT
   } phase_t;

   localparam int TIMEOUT_DEF = 15;
   localparam int TMR_W_DEF   = 4;

endpackage

// File: rtl/dlx_mem_timer.sv
// Memory wait counter: counts unacknowledged request cycles and flags
// the cycle on which the count reaches TIMEOUT.
module dlx_mem_timer
   import dlx_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TMR_W   = TMR_W_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires on the cycle whose unacked wait would bring the count to TIMEOUT.
   assign expired_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/dlx_phase_seq.sv
// DLX multicycle phase sequencer: IF/ID/EX/MEM/WB strobes, memory
// handshake, writeback gating, halt handling and retired count.
module dlx_phase_seq
   import dlx_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TMR_W   = TMR_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        halt_req,
   input  logic        is_mem,
   input  logic        writes_rd,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_is_data,
   output logic        ir_load,
   output logic        pc_load,
   output logic        IF,
   output logic        ID,
   output logic        EX,
   output logic        MEM,
   output logic        WB,
   output logic        reg_s_enable,
   output logic        busy,
   output logic        bus_err,
   output logic [31:0] instret
);

   phase_t      state_q;
   phase_t      state_d;
   logic        halt_pend_q;
   logic        halt_pend_d;
   logic [31:0] instret_q;
   logic [31:0] instret_d;
   logic        expired;
   logic        tmr_clr;
   logic        tmr_en;

   assign tmr_clr = ~mem_req | mem_ack;
   assign tmr_en  = mem_req & ~mem_ack;

   dlx_mem_timer #(
      .TIMEOUT (TIMEOUT),
      .TMR_W   (TMR_W)
   ) u_timer (
      .clk_i     (clk),
      .rst_i     (reset),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         halt_pend_q <= 1'b0;
         instret_q   <= '0;
      end else begin
         state_q     <= state_d;
         halt_pend_q <= halt_pend_d;
         instret_q   <= instret_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      halt_pend_d = halt_pend_q;
      instret_d   = instret_q;
      unique case (state_q)
         IDLE, HALTED: begin
            halt_pend_d = 1'b0;
            if (start) state_d = IF_S;
         end
         IF_S: begin
            if (halt_req) halt_pend_d = 1'b1;
            if (mem_ack) state_d = ID_S;
            else if (expired) state_d = FAULT;
         end
         ID_S: begin
            if (halt_req) halt_pend_d = 1'b1;
            state_d = EX_S;
         end
         EX_S: begin
            if (halt_req) halt_pend_d = 1'b1;
            state_d = is_mem ? MEM_S : WB_S;
         end
         MEM_S: begin
            if (halt_req) halt_pend_d = 1'b1;
            if (mem_ack) state_d = WB_S;
            else if (expired) state_d = FAULT;
         end
         WB_S: begin
            halt_pend_d = 1'b0;
            instret_d   = instret_q + 32'd1;
            state_d     = (halt_pend_q | halt_req) ? HALTED : IF_S;
         end
         FAULT: state_d = FAULT;
      endcase
   end

   always_comb begin
      mem_req      = 1'b0;
      mem_is_data  = 1'b0;
      ir_load      = 1'b0;
      pc_load      = 1'b0;
      IF           = 1'b0;
      ID           = 1'b0;
      EX           = 1'b0;
      MEM          = 1'b0;
      WB           = 1'b0;
      reg_s_enable = 1'b0;
      busy         = 1'b0;
      bus_err      = 1'b0;
      unique case (state_q)
         IF_S: begin
            IF      = 1'b1;
            busy    = 1'b1;
            mem_req = 1'b1;
            ir_load = mem_ack;
         end
         ID_S: begin
            ID   = 1'b1;
            busy = 1'b1;
         end
         EX_S: begin
            EX   = 1'b1;
            busy = 1'b1;
         end
         MEM_S: begin
            MEM         = 1'b1;
            busy        = 1'b1;
            mem_req     = 1'b1;
            mem_is_data = 1'b1;
         end
         WB_S: begin
            WB           = 1'b1;
            busy         = 1'b1;
            pc_load      = 1'b1;
            reg_s_enable = writes_rd;
         end
         FAULT: bus_err = 1'b1;
         IDLE, HALTED: ;
      endcase
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_dlx_phase_seq.sv
// Directed self-checking bench for dlx_phase_seq.
module tb_dlx_phase_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        is_mem = 1'b0;
   logic        writes_rd = 1'b0;
   logic        mem_ack = 1'b0;
   logic        mem_req;
   logic        mem_is_data;
   logic        ir_load;
   logic        pc_load;
   logic        IF;
   logic        ID;
   logic        EX;
   logic        MEM;
   logic        WB;
   logic        reg_s_enable;
   logic        busy;
   logic        bus_err;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;

   logic [4:0] ph;
   logic [11:0] allo;
   assign ph = {IF, ID, EX, MEM, WB};
   assign allo = {mem_req, mem_is_data, ir_load, pc_load, ph,
                  reg_s_enable, busy, bus_err};

   localparam logic [4:0] P_IF  = 5'b10000;
   localparam logic [4:0] P_ID  = 5'b01000;
   localparam logic [4:0] P_EX  = 5'b00100;
   localparam logic [4:0] P_MEM = 5'b00010;
   localparam logic [4:0] P_WB  = 5'b00001;
   localparam logic [4:0] P_NO  = 5'b00000;

   dlx_phase_seq #(
      .TIMEOUT (15),
      .TMR_W   (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .halt_req     (halt_req),
      .is_mem       (is_mem),
      .writes_rd    (writes_rd),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_is_data  (mem_is_data),
      .ir_load      (ir_load),
      .pc_load      (pc_load),
      .IF           (IF),
      .ID           (ID),
      .EX           (EX),
      .MEM          (MEM),
      .WB           (WB),
      .reg_s_enable (reg_s_enable),
      .busy         (busy),
      .bus_err      (bus_err),
      .instret      (instret)
   );

   always #5 clk = ~clk;

   // Drive one cycle's inputs at the falling edge, then let outputs settle.
   task automatic cyc(input logic s, input logic h, input logic a);
      @(negedge clk);
      start    = s;
      halt_req = h;
      mem_ack  = a;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      checks++;
      if (allo !== 12'h000) begin
         errors++;
         $display("FAIL reset_outs got %b want 0", allo);
      end
      checks++;
      if (instret !== 32'd0) begin
         errors++;
         $display("FAIL reset_instret got %0d want 0", instret);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_alu();
      logic [4:0] eph [7] = '{P_NO, P_IF, P_IF, P_IF, P_ID, P_EX, P_WB};
      is_mem    = 1'b0;
      writes_rd = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cyc(i == 0, 1'b0, i == 3);
         checks++;
         if (ph !== eph[i]) begin
            errors++;
            $display("FAIL alu_phase[%0d] got %b want %b", i, ph, eph[i]);
         end
         checks++;
         if (reg_s_enable !== (i == 6) || ir_load !== (i == 3)) begin
            errors++;
            $display("FAIL alu_strobes[%0d] got we=%b ir=%b", i,
                     reg_s_enable, ir_load);
         end
      end
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (ph !== P_IF || instret !== 32'd1) begin
         errors++;
         $display("FAIL alu_retire got ph=%b ir=%0d want IF/1", ph, instret);
      end
   endtask

   task automatic test_load();
      logic [4:0] eph [11] = '{P_IF, P_ID, P_EX, P_MEM, P_MEM, P_MEM,
                               P_MEM, P_MEM, P_MEM, P_WB, P_IF};
      int pcl = 0;
      is_mem    = 1'b1;
      writes_rd = 1'b1;
      for (int i = 0; i < 11; i++) begin
         cyc(1'b0, 1'b0, (i == 0) || (i == 8));
         pcl += int'(pc_load);
         checks++;
         if (ph !== eph[i]) begin
            errors++;
            $display("FAIL load_phase[%0d] got %b want %b", i, ph, eph[i]);
         end
         if (eph[i] == P_MEM) begin
            checks++;
            if (mem_req !== 1'b1 || mem_is_data !== 1'b1) begin
               errors++;
               $display("FAIL load_memdata[%0d] got req=%b d=%b want 1/1",
                        i, mem_req, mem_is_data);
            end
         end
      end
      checks++;
      if (pcl != 1) begin
         errors++;
         $display("FAIL load_pcload got %0d pulses want 1", pcl);
      end
      checks++;
      if (instret !== 32'd2) begin
         errors++;
         $display("FAIL load_instret got %0d want 2", instret);
      end
   endtask

   task automatic test_store();
      logic [4:0] eph [6] = '{P_IF, P_ID, P_EX, P_MEM, P_WB, P_IF};
      is_mem    = 1'b1;
      writes_rd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b0, (i == 0) || (i == 3));
         checks++;
         if (ph !== eph[i]) begin
            errors++;
            $display("FAIL store_phase[%0d] got %b want %b", i, ph, eph[i]);
         end
         if (i == 4) begin
            checks++;
            if (reg_s_enable !== 1'b0 || pc_load !== 1'b1) begin
               errors++;
               $display("FAIL store_wb got we=%b pc=%b want 0/1",
                        reg_s_enable, pc_load);
            end
         end
      end
      checks++;
      if (instret !== 32'd3) begin
         errors++;
         $display("FAIL store_instret got %0d want 3", instret);
      end
   endtask

   task automatic test_halt();
      logic [4:0] eph [10] = '{P_IF, P_ID, P_EX, P_WB, P_NO,
                               P_IF, P_ID, P_EX, P_WB, P_IF};
      is_mem    = 1'b0;
      writes_rd = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(i == 4, i == 2, (i == 0) || (i == 5));
         checks++;
         if (ph !== eph[i]) begin
            errors++;
            $display("FAIL halt_phase[%0d] got %b want %b", i, ph, eph[i]);
         end
         if (i == 4) begin
            checks++;
            if (busy !== 1'b0 || instret !== 32'd4) begin
               errors++;
               $display("FAIL halt_state got busy=%b ir=%0d want 0/4",
                        busy, instret);
            end
         end
      end
      checks++;
      if (instret !== 32'd5) begin
         errors++;
         $display("FAIL halt_resume_instret got %0d want 5", instret);
      end
   endtask

   task automatic test_reset_in_mem();
      int we = 0;
      is_mem    = 1'b1;
      writes_rd = 1'b1;
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (ph !== P_MEM) begin
         errors++;
         $display("FAIL rstmem_pre got %b want %b", ph, P_MEM);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (allo !== 12'h000 || instret !== 32'd0) begin
         errors++;
         $display("FAIL rstmem_async got %b ir=%0d want 0/0", allo, instret);
      end
      cyc(1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         we += int'(reg_s_enable);
      end
      checks++;
      if (we != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmem_after got we=%0d busy=%b want 0/0", we, busy);
      end
   endtask

   task automatic test_timeout();
      is_mem = 1'b0;
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         checks++;
         if (ph !== P_IF || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL tmo_wait[%0d] got ph=%b req=%b want IF/1",
                     i, ph, mem_req);
         end
      end
      cyc(1'b1, 1'b0, 1'b1);
      checks++;
      if (bus_err !== 1'b1 || mem_req !== 1'b0 || ph !== P_NO) begin
         errors++;
         $display("FAIL tmo_fault got err=%b req=%b ph=%b want 1/0/0",
                  bus_err, mem_req, ph);
      end
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (bus_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL tmo_sticky got err=%b busy=%b want 1/0",
                  bus_err, busy);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus_err !== 1'b0) begin
         errors++;
         $display("FAIL tmo_reset got err=%b want 0", bus_err);
      end
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      checks++;
      if (ph !== P_IF || ir_load !== 1'b1) begin
         errors++;
         $display("FAIL tmo_edge_ack got ph=%b ir=%b want IF/1", ph, ir_load);
      end
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (ph !== P_ID || bus_err !== 1'b0) begin
         errors++;
         $display("FAIL tmo_edge_nofault got ph=%b err=%b want ID/0",
                  ph, bus_err);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_halt();
      test_reset_in_mem();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
